disp_scan_mux: RTL and testbench

Multiplexed seven-segment display scanner that consumes the periodic one-cycle display strobe from the display clock divider and drives the board's common-anode digit array. It holds a frame-stable copy of the value to show, time-multiplexes one digit per strobe, inserts a short all-off interval between digits to suppress ghosting, and accepts new values through a load/acknowledge handshake that commits only at frame boundaries.

---
 rtl/disp_scan_mux.sv | 216 +++++++++++++++++++++
 tb/tb_disp_scan_mux.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_mux.sv
// disp_scan_mux: multiplexed common-anode seven-segment scanner.
// Shows one digit per display strobe with an all-off gap between digits.
// New values are accepted through a load/ack handshake and committed only
// when the scan wraps to digit 0.
// Optional feature: define DISP_LZ_BLANK_EN for leading-zero suppression.
module disp_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW         = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int BLANK_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_flag_q, pend_flag_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    load_ack_q, load_ack_d;
    logic                    frame_start_q, frame_start_d;

    logic                    enter_drive;
    logic                    wrap;
    logic                    digit_on;
    logic [3:0]              disp_nib [NUM_DIGITS];

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Nibble view of the value that will be on display next cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign disp_nib[gi] = disp_val_d[4*gi +: 4];
        end
    endgenerate

`ifdef DISP_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] nz;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
            assign nz[gi] = |disp_nib[gi];
        end
    endgenerate
    // A digit is lit if it is digit 0 or some nibble at or above it is nonzero.
    assign digit_on = (idx_d == '0) || (|(nz >> idx_d));
`else
    assign digit_on = 1'b1;
`endif

    // Scan sequencing, commit at the digit-0 wrap, and load capture.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;
        enter_drive = 1'b0;
        wrap        = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (tick) begin
                    idx_d = '0;
                    wrap  = 1'b1;
                    if (BLANK_CYC == 0) begin
                        state_d     = ST_DRIVE;
                        enter_drive = 1'b1;
                    end else begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                    end
                end
            end
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK_LAST)) begin
                    state_d     = ST_DRIVE;
                    enter_drive = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRIVE: begin
                if (tick) begin
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    wrap  = (idx_q == IDX_LAST);
                    if (BLANK_CYC == 0) begin
                        enter_drive = 1'b1;
                    end else begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        // Commit consumes the old pending contents before a same-cycle load.
        load_ack_d = wrap & pend_flag_q;
        if (load_ack_d) begin
            disp_val_d  = pend_val_q;
            disp_dp_d   = pend_dp_q;
            pend_flag_d = 1'b0;
        end
        if (load) begin
            pend_val_d  = value_in;
            pend_dp_d   = dp_in;
            pend_flag_d = 1'b1;
        end
    end

    // Next-cycle pin values derived from next state so every output is a flop.
    always_comb begin
        an_d          = '1;
        seg_d         = 7'h7F;
        dp_d          = 1'b1;
        frame_start_d = enter_drive && (idx_d == '0);
        if ((state_d == ST_DRIVE) && digit_on) begin
            an_d[idx_d] = 1'b0;
            seg_d       = seg_encode(disp_nib[idx_d]);
            dp_d        = ~disp_dp_d[idx_d];
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_OFF;
            idx_q         <= '0;
            cnt_q         <= '0;
            disp_val_q    <= '0;
            disp_dp_q     <= '0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_flag_q   <= 1'b0;
            an_q          <= '1;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            disp_val_q    <= disp_val_d;
            disp_dp_q     <= disp_dp_d;
            pend_val_q    <= pend_val_d;
            pend_dp_q     <= pend_dp_d;
            pend_flag_q   <= pend_flag_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign load_ack    = load_ack_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Bench for disp_scan_mux: one instance with a 16-cycle gap, one with no gap.
// A timeline model predicts every output each cycle; literal checks pin it.
module tb_disp_scan_mux;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value_in = 16'h0;
    logic [3:0]    dp_in = 4'h0;

    logic          ack_a, dp_a, fs_a;
    logic [3:0]    an_a;
    logic [6:0]    seg_a;
    logic          ack_b, dp_b, fs_b;
    logic [3:0]    an_b;
    logic [6:0]    seg_b;

    int n_checks = 0;
    int n_pass   = 0;
    int acks_a   = 0;
    int acks_b   = 0;

    disp_scan_mux #(.NUM_DIGITS(N), .BLANK_CYC(16)) dut_a (
        .clk(clk), .reset(reset), .tick(tick), .value_in(value_in), .dp_in(dp_in),
        .load(load), .load_ack(ack_a), .an(an_a), .seg(seg_a), .dp(dp_a),
        .frame_start(fs_a)
    );

    disp_scan_mux #(.NUM_DIGITS(N), .BLANK_CYC(0)) dut_b (
        .clk(clk), .reset(reset), .tick(tick), .value_in(value_in), .dp_in(dp_in),
        .load(load), .load_ack(ack_b), .an(an_b), .seg(seg_b), .dp(dp_b),
        .frame_start(fs_b)
    );

    always #5 clk = ~clk;

    // ---------------- timeline model ----------------
    logic [6:0] enc [0:15] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    int          gap [2] = '{16, 0};
    longint      cyc = 0;
    bit          m_run [2];
    int          m_idx [2];
    longint      m_drive_at [2];
    logic [15:0] m_disp [2];
    logic [3:0]  m_ddp [2];
    bit          m_pend [2];
    logic [15:0] m_pv [2];
    logic [3:0]  m_pdp [2];
    bit          m_ack [2];
    bit          m_fs [2];

    // One clock edge: a tick is honoured when the scan is off or the digit
    // slot was already lit in the previous cycle; the new digit lights
    // 'gap' cycles after the honoured tick.
    task automatic model_step(input int k);
        m_ack[k] = 1'b0;
        m_fs[k]  = 1'b0;
        if (!reset) begin
            m_run[k] = 1'b0; m_idx[k] = 0; m_drive_at[k] = 0;
            m_disp[k] = 16'h0; m_ddp[k] = 4'h0; m_pend[k] = 1'b0;
        end else begin
            if (tick && (!m_run[k] || (cyc - 1 >= m_drive_at[k]))) begin
                m_idx[k]      = m_run[k] ? (m_idx[k] + 1) % N : 0;
                m_run[k]      = 1'b1;
                m_drive_at[k] = cyc + gap[k];
                if (m_idx[k] == 0 && m_pend[k]) begin
                    m_disp[k] = m_pv[k];
                    m_ddp[k]  = m_pdp[k];
                    m_pend[k] = 1'b0;
                    m_ack[k]  = 1'b1;
                end
            end
            if (load) begin
                m_pv[k]   = value_in;
                m_pdp[k]  = dp_in;
                m_pend[k] = 1'b1;
            end
            m_fs[k] = m_run[k] && (cyc == m_drive_at[k]) && (m_idx[k] == 0);
        end
    endtask

    // Expected {an, seg, dp, load_ack, frame_start} for the current cycle.
    function automatic logic [13:0] exp_vec(input int k);
        logic [3:0] a;
        logic       show;
        int         i;
        if (!reset) return {4'hF, 7'h7F, 1'b1, 2'b00};
        if (!m_run[k] || cyc < m_drive_at[k]) return {4'hF, 7'h7F, 1'b1, m_ack[k], m_fs[k]};
        i    = m_idx[k];
        show = 1'b1;
`ifdef DISP_LZ_BLANK_EN
        show = (i == 0);
        for (int j = i; j < N; j++) if (m_disp[k][4*j +: 4] != 4'h0) show = 1'b1;
`endif
        if (!show) return {4'hF, 7'h7F, 1'b1, m_ack[k], m_fs[k]};
        a    = 4'hF;
        a[i] = 1'b0;
        return {a, enc[m_disp[k][4*i +: 4]], ~m_ddp[k][i], m_ack[k], m_fs[k]};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step(0);
        model_step(1);
    end

    // Per-cycle comparison of both instances against the model.
    initial forever begin
        logic [13:0] ga, gb, ea, eb;
        @(negedge clk);
        ga = {an_a, seg_a, dp_a, ack_a, fs_a};
        gb = {an_b, seg_b, dp_b, ack_b, fs_b};
        ea = exp_vec(0);
        eb = exp_vec(1);
        n_checks++;
        if (ga === ea) n_pass++;
        else $display("FAIL scan_gap16 cyc=%0d got=%h exp=%h", cyc, ga, ea);
        n_checks++;
        if (gb === eb) n_pass++;
        else $display("FAIL scan_gap0 cyc=%0d got=%h exp=%h", cyc, gb, eb);
        if (ack_a === 1'b1) acks_a++;
        if (ack_b === 1'b1) acks_b++;
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick(input int len);
        tick = 1'b1;
        step_n(1);
        tick = 1'b0;
        $display("[%0t] tick", $time);
        step_n(len - 1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value_in = v; dp_in = d;
        step_n(1);
        load = 1'b0;
        $display("[%0t] load %h dp %b", $time, v, d);
    endtask

    task automatic do_tick_load(input logic [15:0] v, input logic [3:0] d, input int len);
        tick = 1'b1; load = 1'b1; value_in = v; dp_in = d;
        step_n(1);
        tick = 1'b0; load = 1'b0;
        $display("[%0t] tick+load %h", $time, v);
        step_n(len - 1);
    endtask

    initial begin
        int base_a, base_b;
        #1 reset = 1'b0;
        step_n(3);
        reset = 1'b1;

        // idle after reset
        step_n(100);
        chk("idle_a", {an_a, seg_a, dp_a, ack_a, fs_a}, {4'hF, 7'h7F, 1'b1, 2'b00});
        chk("idle_b", {an_b, seg_b, dp_b, ack_b, fs_b}, {4'hF, 7'h7F, 1'b1, 2'b00});
        chk("idle_acks", acks_a + acks_b, 0);

        // first tick
        tick = 1'b1;
        step_n(1);
        tick = 1'b0;
        chk("gap0_first", {an_b, seg_b, dp_b, fs_b}, {4'b1110, 7'b1000000, 1'b1, 1'b1});
        step_n(15);
        chk("gap16_still_blank", an_a, 4'hF);
        step_n(1);
        chk("gap16_first", {an_a, seg_a, dp_a, fs_a}, {4'b1110, 7'b1000000, 1'b1, 1'b1});

        // load 12AF, commit at next wrap, scan one frame
        do_load(16'h12AF, 4'b0010);
        repeat (4) do_tick(20);
        chk("load_ack_once", acks_a, 1);
        chk("dig0_F", {an_a, seg_a, dp_a}, {4'b1110, 7'b0001110, 1'b1});
        chk("dig0_F_gap0", {an_b, seg_b, dp_b}, {4'b1110, 7'b0001110, 1'b1});
        do_tick(20);
        chk("dig1_A_dp", {an_a, seg_a, dp_a}, {4'b1101, 7'b0001000, 1'b0});
        do_tick(20);
        chk("dig2_2", {an_a, seg_a, dp_a}, {4'b1011, 7'b0100100, 1'b1});
        do_tick(20);
        chk("dig3_1", {an_a, seg_a, dp_a}, {4'b0111, 7'b1111001, 1'b1});
        chk("dig3_1_gap0", {an_b, seg_b, dp_b}, {4'b0111, 7'b1111001, 1'b1});

        // two loads before a wrap: newest wins, single ack
        base_a = acks_a;
        do_load(16'h1111, 4'h0);
        do_load(16'h2222, 4'h0);
        do_tick(20);
        chk("newest_wins", {an_a, seg_a, dp_a}, {4'b1110, 7'b0100100, 1'b1});
        chk("double_load_one_ack", acks_a - base_a, 1);

        // load in the same cycle as a commit
        do_load(16'h3333, 4'h0);
        repeat (3) do_tick(20);
        do_tick_load(16'h4444, 4'h0, 20);
        chk("commit_old_pending", {an_a, seg_a, dp_a}, {4'b1110, 7'b0110000, 1'b1});
        repeat (4) do_tick(20);
        chk("commit_next_wrap", {an_a, seg_a, dp_a}, {4'b1110, 7'b0011001, 1'b1});

        // tick during the gap is ignored
        tick = 1'b1; step_n(1); tick = 1'b0;
        step_n(4);
        tick = 1'b1; step_n(1); tick = 1'b0;
        step_n(10);
        chk("gap_still_blank", an_a, 4'hF);
        step_n(1);
        chk("blank_tick_ignored", {an_a, seg_a}, {4'b1101, 7'b0011001});
        step_n(3);

        // leading-zero handling
        do_load(16'h0070, 4'h0);
        repeat (3) do_tick(20);
        chk("lz_dig0", {an_a, seg_a, dp_a}, {4'b1110, 7'b1000000, 1'b1});
        do_tick(20);
        chk("lz_dig1", {an_a, seg_a, dp_a}, {4'b1101, 7'b1111000, 1'b1});
        do_tick(20);
`ifdef DISP_LZ_BLANK_EN
        chk("lz_dig2", {an_a, seg_a, dp_a}, {4'b1111, 7'h7F, 1'b1});
`else
        chk("lz_dig2", {an_a, seg_a, dp_a}, {4'b1011, 7'b1000000, 1'b1});
`endif
        do_load(16'h0000, 4'h0);
        do_tick(20);
        do_tick(20);
        chk("zero_dig0", {an_a, seg_a, dp_a}, {4'b1110, 7'b1000000, 1'b1});
        do_tick(20);
`ifdef DISP_LZ_BLANK_EN
        chk("zero_dig1", {an_a, seg_a, dp_a}, {4'b1111, 7'h7F, 1'b1});
`else
        chk("zero_dig1", {an_a, seg_a, dp_a}, {4'b1101, 7'b1000000, 1'b1});
`endif

        // reset mid-drive with a pending value
        do_load(16'h5555, 4'hF);
        reset = 1'b0;
        #1;
        chk("rst_async_a", {an_a, seg_a, dp_a, ack_a, fs_a}, {4'hF, 7'h7F, 1'b1, 2'b00});
        chk("rst_async_b", {an_b, seg_b, dp_b, ack_b, fs_b}, {4'hF, 7'h7F, 1'b1, 2'b00});
        step_n(2);
        reset = 1'b1;
        base_a = acks_a;
        base_b = acks_b;

        // no gap: anode rotates on every tick
        do_tick(5);
        chk("rot0", an_b, 4'b1110);
        do_tick(5);
        chk("rot1", an_b, 4'b1101);
        do_tick(5);
        chk("rot2", an_b, 4'b1011);
        do_tick(5);
        chk("rot3", an_b, 4'b0111);
        do_tick(5);
        chk("rot_wrap", an_b, 4'b1110);

        repeat (8) do_tick(20);
        chk("no_ack_after_rst_a", acks_a - base_a, 0);
        chk("no_ack_after_rst_b", acks_b - base_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
